// File: rtl/arb_pkg.sv
// Shared types and elaboration-time helpers for the LRG matrix arbiter.
// The priority triangle is stored row-major over the pairs i<j.
package arb_pkg;

   localparam int MAX_REQ = 32;
   localparam int TRI_MAX = MAX_REQ * (MAX_REQ - 1) / 2;

   typedef logic [$clog2(MAX_REQ)-1:0] src_idx_t;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } lock_st_e;

   function automatic int tri_cnt(input int n);
      return n * (n - 1) / 2;
   endfunction

   function automatic int tri_pos(input int i, input int j, input int n);
      return i * n - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   // Stored bit (i<j) holds pri[i][j]; index order means j beats i only when j<i.
   function automatic logic [TRI_MAX-1:0] index_order_tri(input int n);
      logic [TRI_MAX-1:0] t;
      t = '0;
      for (int i = 0; i < n; i++) begin
         for (int j = i + 1; j < n; j++) begin
            t[tri_pos(i, j, n)] = (j < i);
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/arb_matrix.sv
// Combinational matrix arbiter: pri_i[i][j]=1 means requester j beats requester i.
module arb_matrix #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ-1:0][NUM_REQ-1:0] pri_i,
   output logic [NUM_REQ-1:0]              grant_o
);

   // A requester wins when no other valid requester beats it.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_o[i] = req_i[i] & ~(|(req_i & pri_i[i]));
      end
   end

endmodule

// File: rtl/arb_matrix_lrg_chk.sv
// Protocol and invariant checks for arb_matrix_lrg: onehot0 grant,
// antisymmetric priority, and held requester stability.
module arb_matrix_lrg_chk
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ-1:0]              grant_i,
   input  logic [NUM_REQ-1:0][NUM_REQ-1:0] pri_i,
   input  logic                            hold_i,
   input  src_idx_t                        hold_idx_i,
   input  logic [NUM_REQ-1:0]              req_vld_i,
   input  logic [DATA_W-1:0]               out_data_i
);

   logic [DATA_W-1:0] data_prev_q;

   // Remember last cycle's payload to compare against while held.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_prev_q <= '0;
      end else begin
         data_prev_q <= out_data_i;
      end
   end

   // Invariant checks, sampled on the clock edge outside reset.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(grant_i));
         for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
               if (i != j) begin
                  assert (pri_i[i][j] != pri_i[j][i]);
               end
            end
         end
         if (hold_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (hold_idx_i == src_idx_t'(i)) begin
                  assert (req_vld_i[i]);
               end
            end
            assert (out_data_i == data_prev_q);
         end
      end
   end

endmodule

// File: rtl/arb_matrix_lrg.sv
// N-way arbiter with internal least-recently-granted priority triangle,
// backpressure hold, optional packet lock and a muxed valid/ready output.
module arb_matrix_lrg
   import arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 32,
   parameter  int LOCK_EN = 1,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_vld,
   input  logic [DATA_W-1:0]    req_data [NUM_REQ],
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_rdy,
   output logic                 out_vld,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last,
   output logic [IDX_W-1:0]     out_src,
   input  logic                 out_rdy
);

   localparam int                 TRI_W        = tri_cnt(NUM_REQ);
   localparam logic [TRI_MAX-1:0] PRI_RST_FULL = index_order_tri(NUM_REQ);
   localparam logic [TRI_W-1:0]   PRI_RST      = PRI_RST_FULL[TRI_W-1:0];

   logic [TRI_W-1:0]              pri_tri_q, pri_tri_d;
   logic [NUM_REQ-1:0][NUM_REQ-1:0] pri_s;
   logic [NUM_REQ-1:0]            grant_s;
   src_idx_t                      gnt_idx_s, sel_idx_s;
   src_idx_t                      hold_idx_q, hold_idx_d, lock_idx_q, lock_idx_d;
   logic                          hold_q, hold_d, lock_s, sel_any_s, accept_s, upd_s;
   lock_st_e                      state_q, state_d;

   // Expand the stored triangle into the full antisymmetric matrix.
   always_comb begin
      pri_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (i < j) begin
               pri_s[i][j] = pri_tri_q[tri_pos(i, j, NUM_REQ)];
            end else if (i > j) begin
               pri_s[i][j] = ~pri_tri_q[tri_pos(j, i, NUM_REQ)];
            end else begin
               pri_s[i][j] = 1'b0;
            end
         end
      end
   end

   arb_matrix #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i   (req_vld),
      .pri_i   (pri_s),
      .grant_o (grant_s)
   );

   // Encode the one-hot grant and apply lock > hold > matrix selection.
   always_comb begin
      gnt_idx_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            gnt_idx_s = src_idx_t'(i);
         end else begin
            gnt_idx_s = gnt_idx_s;
         end
      end
      if (lock_s) begin
         sel_idx_s = lock_idx_q;
         sel_any_s = 1'b1;
      end else if (hold_q) begin
         sel_idx_s = hold_idx_q;
         sel_any_s = 1'b1;
      end else begin
         sel_idx_s = gnt_idx_s;
         sel_any_s = |grant_s;
      end
   end

   // Mux the selected requester onto the output channel.
   always_comb begin
      out_vld  = 1'b0;
      out_data = '0;
      out_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_idx_s == src_idx_t'(i)) begin
            out_vld  = sel_any_s & req_vld[i];
            out_data = req_data[i];
            out_last = req_last[i];
         end else begin
            out_vld  = out_vld;
         end
      end
      out_src  = sel_idx_s[IDX_W-1:0];
      accept_s = out_vld & out_rdy;
      upd_s    = accept_s & ((LOCK_EN == 0) | out_last);
   end

   // Ready goes back only to the selected requester on an accept.
   always_comb begin
      req_rdy = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_rdy[i] = (sel_idx_s == src_idx_t'(i)) & accept_s;
      end
   end

   // Winner drops to lowest priority: pri[g][j]=1, pri[j][g]=0.
   always_comb begin
      pri_tri_d = pri_tri_q;
      if (upd_s) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
               if (sel_idx_s == src_idx_t'(i)) begin
                  pri_tri_d[tri_pos(i, j, NUM_REQ)] = 1'b1;
               end else if (sel_idx_s == src_idx_t'(j)) begin
                  pri_tri_d[tri_pos(i, j, NUM_REQ)] = 1'b0;
               end else begin
                  pri_tri_d[tri_pos(i, j, NUM_REQ)] = pri_tri_q[tri_pos(i, j, NUM_REQ)];
               end
            end
         end
      end else begin
         pri_tri_d = pri_tri_q;
      end
   end

   // Hold latches the source of a stalled beat.
   always_comb begin
      if (out_vld & ~out_rdy) begin
         hold_d     = 1'b1;
         hold_idx_d = sel_idx_s;
      end else begin
         hold_d     = 1'b0;
         hold_idx_d = hold_idx_q;
      end
   end

   // Priority triangle and hold registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_tri_q  <= PRI_RST;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         pri_tri_q  <= pri_tri_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   // Lock FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ARB;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // Lock FSM next state: a non-last accept locks, a last accept unlocks.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         ST_ARB: begin
            if ((LOCK_EN != 0) && accept_s && !out_last) begin
               state_d    = ST_LOCKED;
               lock_idx_d = sel_idx_s;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_LOCKED: begin
            if (accept_s && out_last) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // Lock FSM outputs.
   always_comb begin
      lock_s = (state_q == ST_LOCKED);
   end

   arb_matrix_lrg_chk #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) u_chk (
      .clk_i      (clk),
      .rst_i      (rst),
      .grant_i    (grant_s),
      .pri_i      (pri_s),
      .hold_i     (hold_q),
      .hold_idx_i (hold_idx_q),
      .req_vld_i  (req_vld),
      .out_data_i (out_data)
   );

endmodule

// File: tb/tb_arb_matrix_lrg.sv
// Directed bench for arb_matrix_lrg: one locking instance and one non-locking
// instance, each driven by its own request set with hand-computed expectations.
module tb_arb_matrix_lrg;

   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0] vld_l, last_l, rdy_o_l;
   logic [W-1:0] data_l [N];
   logic         rdy_l, ovld_l, olast_l;
   logic [W-1:0] odata_l;
   logic [1:0]   osrc_l;

   logic [N-1:0] vld_n, last_n, rdy_o_n;
   logic [W-1:0] data_n [N];
   logic         rdy_n, ovld_n, olast_n;
   logic [W-1:0] odata_n;
   logic [1:0]   osrc_n;

   int checks   = 0;
   int failures = 0;
   int ord_lrg [3] = '{3, 0, 2};
   int ord_nl  [5] = '{0, 1, 0, 1, 0};

   arb_matrix_lrg #(.NUM_REQ(N), .DATA_W(W), .LOCK_EN(1)) u_dut_l (
      .clk(clk), .rst(rst), .req_vld(vld_l), .req_data(data_l), .req_last(last_l),
      .req_rdy(rdy_o_l), .out_vld(ovld_l), .out_data(odata_l), .out_last(olast_l),
      .out_src(osrc_l), .out_rdy(rdy_l)
   );

   arb_matrix_lrg #(.NUM_REQ(N), .DATA_W(W), .LOCK_EN(0)) u_dut_n (
      .clk(clk), .rst(rst), .req_vld(vld_n), .req_data(data_n), .req_last(last_n),
      .req_rdy(rdy_o_n), .out_vld(ovld_n), .out_data(odata_n), .out_last(olast_n),
      .out_src(osrc_n), .out_rdy(rdy_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_l(input string tag, input logic v, input int src, input logic [N-1:0] rdy);
      #1;
      chk({tag, "_vld"}, 32'(ovld_l), 32'(v));
      if (v) chk({tag, "_src"}, 32'(osrc_l), src);
      chk({tag, "_rdy"}, 32'(rdy_o_l), 32'(rdy));
   endtask

   task automatic exp_n(input string tag, input logic v, input int src, input logic [N-1:0] rdy);
      #1;
      chk({tag, "_vld"}, 32'(ovld_n), 32'(v));
      if (v) chk({tag, "_src"}, 32'(osrc_n), src);
      chk({tag, "_rdy"}, 32'(rdy_o_n), 32'(rdy));
   endtask

   task automatic do_rst();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int b;
      rst = 1'b1;
      vld_l = '0; last_l = '0; rdy_l = 1'b1;
      vld_n = '0; last_n = '0; rdy_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         data_l[i] = 32'hD0 + 32'(i);
         data_n[i] = 32'hD0 + 32'(i);
      end
      #3;
      exp_l("rst_l", 1'b0, 0, 4'b0000);
      exp_n("rst_n", 1'b0, 0, 4'b0000);
      cyc();
      rst = 1'b0;

      // Reset fairness: all valid, single-beat packets
      vld_l = 4'hF; last_l = 4'hF; rdy_l = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_l($sformatf("fair%0d", k), 1'b1, k % 4, 4'b0001 << (k % 4));
         cyc();
      end

      // LRG update: grant 0 then 2, then 0/2/3 together -> 3,0,2
      do_rst();
      vld_l = 4'b0001;
      exp_l("lrg_a", 1'b1, 0, 4'b0001);
      cyc();
      vld_l = 4'b0100;
      exp_l("lrg_b", 1'b1, 2, 4'b0100);
      cyc();
      vld_l = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         exp_l($sformatf("lrg%0d", k), 1'b1, ord_lrg[k], 4'b0001 << ord_lrg[k]);
         cyc();
      end

      // Lock: req0 3-beat packet while req1 waits
      do_rst();
      vld_l = 4'b0011; last_l = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         last_l[0] = (k == 2);
         data_l[0] = 32'hA0 + 32'(k);
         exp_l($sformatf("lock%0d", k), 1'b1, 0, 4'b0001);
         chk($sformatf("lock_data%0d", k), odata_l, 32'hA0 + 32'(k));
         cyc();
      end
      exp_l("lock_after", 1'b1, 1, 4'b0010);
      cyc();
      vld_l = '0;

      // Same traffic without locking alternates every beat
      vld_n = 4'b0011; last_n = 4'b0010; b = 0;
      for (int k = 0; k < 5; k++) begin
         last_n[0] = (b == 2);
         data_n[0] = 32'hA0 + 32'(b);
         exp_n($sformatf("nolock%0d", k), 1'b1, ord_nl[k], 4'b0001 << ord_nl[k]);
         if (ord_nl[k] == 0) b++;
         cyc();
      end
      vld_n = '0;

      // Backpressure hold on req2, then req0 arrives
      do_rst();
      vld_l = 4'b0100; last_l = 4'hF; rdy_l = 1'b0; data_l[2] = 32'hC2;
      for (int k = 0; k < 5; k++) begin
         exp_l($sformatf("bp%0d", k), 1'b1, 2, 4'b0000);
         chk($sformatf("bp_data%0d", k), odata_l, 32'hC2);
         cyc();
      end
      vld_l = 4'b0101;
      exp_l("bp_arr", 1'b1, 2, 4'b0000);
      chk("bp_arr_data", odata_l, 32'hC2);
      cyc();
      rdy_l = 1'b1;
      exp_l("bp_acc", 1'b1, 2, 4'b0100);
      cyc();
      vld_l = 4'b0001;
      exp_l("bp_next", 1'b1, 0, 4'b0001);
      cyc();

      // Lock bubble: locked req1 drops vld for 2 cycles
      do_rst();
      vld_l = 4'b0010; last_l = 4'b1101;
      exp_l("bub_first", 1'b1, 1, 4'b0010);
      cyc();
      vld_l = 4'b0101;
      for (int k = 0; k < 2; k++) begin
         exp_l($sformatf("bub%0d", k), 1'b0, 0, 4'b0000);
         cyc();
      end
      vld_l = 4'b0111; last_l = 4'hF;
      exp_l("bub_end", 1'b1, 1, 4'b0010);
      cyc();
      exp_l("bub_after", 1'b1, 0, 4'b0001);
      cyc();

      // Reset mid-packet from req3
      do_rst();
      vld_l = 4'b0001; last_l = 4'hF;
      exp_l("rmp_pre", 1'b1, 0, 4'b0001);
      cyc();
      vld_l = 4'b1000; last_l = 4'b0111;
      exp_l("rmp_lock", 1'b1, 3, 4'b1000);
      cyc();
      vld_l = 4'b1011;
      exp_l("rmp_held", 1'b1, 3, 4'b1000);
      do_rst();
      exp_l("rmp_after", 1'b1, 0, 4'b0001);
      cyc();
      exp_l("rmp_next", 1'b1, 1, 4'b0010);
      cyc();
      vld_l = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_matrix_lrg.md
# arb_matrix_lrg

Sequential N-way matrix arbiter with an internal least-recently-granted (LRG) priority matrix, valid/ready handshakes on every requester and on the shared output, and optional packet locking. It replaces externally supplied priority matrices in the interconnect and shared-resource front ends. It muxes the winning requester's payload onto a single downstream channel. Combinational grant evaluation uses the same matrix convention as `arb_matrix`: `pri[i][j]=1` means requester j beats requester i.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 32: payload width.
- `LOCK_EN`, 1: when 1, grant is held from first beat through the `last` beat of a packet; when 0, every beat is arbitrated.

Ports. Reset is asynchronous and active-high; everything else is synchronous to the rising edge of `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_vld`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ x DATA_W  per-requester payload (unpacked array).
- `req_last`  in  NUM_REQ  last beat of packet.
- `req_rdy`  out  NUM_REQ  per-requester ready.
- `out_vld`  out  1  output valid.
- `out_data`  out  DATA_W  granted payload.
- `out_last`  out  1  granted last flag.
- `out_src`  out  $clog2(NUM_REQ)  index of granted requester.
- `out_rdy`  in  1  downstream ready.

## Operation
- **Priority state**
  - Store only the upper triangle: `pri[i][j]` for i<j, which is NUM_REQ*(NUM_REQ-1)/2 flops.
  - The lower triangle is derived as `pri[j][i] = ~pri[i][j]`, so the matrix is always antisymmetric and acyclic.
  - Reset value: lower index has highest priority, i.e. `pri[i][j]=1` iff j<i.
- **Grant**
  - `grant[i] = req_vld[i] & ~|(req_vld & pri[i])`.
  - Exactly one bit is set whenever any `req_vld` is set.
- **Hold state**
  - `hold_q` and `hold_idx_q` latch the source when `out_vld & ~out_rdy`.
  - While `hold_q` is set, the latched source is selected regardless of new higher-priority arrivals.
  - Requesters must keep `vld` and payload stable until `rdy`. Dropping `vld` while held is a protocol violation; it is flagged by an assertion only.
- **Lock state** (LOCK_EN=1 only)
  - `lock_q` and `lock_idx_q` are set when a beat with `last=0` is accepted.
  - They clear when a beat with `last=1` is accepted from `lock_idx_q`.
  - While locked, only `lock_idx_q` may be selected. If it deasserts `vld`, `out_vld=0` and other requesters wait.
- **Selection priority**: lock, then hold, then matrix grant.
- **Output path**
  - `out_vld = req_vld[sel]` when a selection exists.
  - `out_data`, `out_last` and `out_src` are muxed from `sel`.
  - `req_rdy[i] = (sel==i) & out_vld & out_rdy`; all other `req_rdy` are 0.
- **Priority update**
  - Triggered on accept (`out_vld & out_rdy`) when LOCK_EN=0, or when LOCK_EN=1 and `out_last=1`.
  - Winner g becomes lowest priority: `pri[g][j]=1` and `pri[j][g]=0` for all j≠g.
  - Mid-packet accepts do not update priority.
- **States**: IDLE/ARB (no lock), LOCKED. The hold flag is orthogonal to both states.

## Timing
- Zero-cycle latency: request to `out_vld` is combinational, and `out_rdy` to `req_rdy` is combinational.
- Priority, hold and lock registers update on the accepting edge; the new priority takes effect the next cycle.
- Reset values:
  - `pri` = index order.
  - `hold_q=0`, `lock_q=0`, indices 0.
  - Outputs are then purely input-driven: `out_vld=0` and all `req_rdy=0` when no `req_vld` is set.
- Reset asserted mid-packet: lock and hold drop immediately (asynchronously) and the matrix returns to index order. There is no partial-packet recovery; upstream is reset too.
- Simultaneous accept of a `last` beat and new requests: the new grant uses the updated matrix from the next cycle.
- A single-beat packet (`last=1` on the first beat) never enters LOCKED.

## Structure
- Package `arb_pkg`:
  - `localparam` helper for the triangle flop count.
  - `function` for index-order reset matrix generation.
  - typedef for the source index.
- Sub-module: `arb_matrix` is instantiated for the combinational grant, with the expanded full matrix fed from the triangle registers.
- Muxing and the hold/lock FSM sit in the top level.
- Assertions:
  - grant is onehot0;
  - `pri` is antisymmetric;
  - requester stability while held.

## Test plan
- **Reset fairness**: NUM_REQ=4, all `req_vld=1` continuously with single-beat packets, `out_rdy=1` -> `out_src` sequence 0,1,2,3,0,1.
- **LRG update**: after 0 and 2 granted, raise req 0, 2 and 3 together -> order 3,0,2.
- **Lock**: LOCK_EN=1, req0 sends a 3-beat packet while req1 is valid -> `out_src`=0 for 3 accepts, then 1. Repeating with LOCK_EN=0 -> 0,1,0,1,0.
- **Backpressure hold**: req2 is granted with `out_rdy=0` for 5 cycles, then req0 rises -> `out_src` stays 2 until accept, then 0. `out_data` stays stable throughout.
- **Lock bubble**: the locked requester drops `vld` for 2 cycles mid-packet while others are valid -> `out_vld=0` for those 2 cycles and no other `req_rdy` is asserted.
- **Reset mid-packet**: `rst` pulsed during a locked packet from req3 -> next arbitration grants lowest valid index, with `lock_q=0`.
